// File: rtl/usb_ep_pkg.sv
// rtl/usb_ep_pkg.sv - shared types and helpers for the CDC serial USB endpoints
package usb_ep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_FILL     = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } ep_state_e;

  // Full-speed bulk endpoints only allow these payload sizes.
  function automatic bit max_pkt_legal(input int n);
    return (n == 8) || (n == 16) || (n == 32) || (n == 64);
  endfunction

  function automatic int ep_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/usb_uart_in_pkt_ep_if.sv
// rtl/usb_uart_in_pkt_ep_if.sv - PE IN-slot and UART byte-stream signals of the IN endpoint
interface usb_uart_in_pkt_ep_if;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;

  // master: the endpoint; slave: PE plus user byte source
  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall, uart_in_ready,
    input  in_ep_grant, in_ep_data_free, in_ep_acked, uart_in_data, uart_in_valid
  );

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall, uart_in_ready,
    output in_ep_grant, in_ep_data_free, in_ep_acked, uart_in_data, uart_in_valid
  );
endinterface

// File: rtl/usb_sync_fifo.sv
// rtl/usb_sync_fifo.sv - single-clock FIFO with level/full/empty and combinational head read
module usb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/usb_uart_in_pkt_ep.sv
// rtl/usb_uart_in_pkt_ep.sv - UART->host IN endpoint packing a byte FIFO into IN packets
// Optional zero-length packet after a full final packet: define USB_IN_EP_ZLP_EN.
module usb_uart_in_pkt_ep
  import usb_ep_pkg::*;
#(
  parameter int FIFO_DEPTH    = 64,
  parameter int MAX_PKT       = 32,
  parameter int FLUSH_TIMEOUT = 48000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          usb_reset,
  usb_uart_in_pkt_ep_if.master          ep_if,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(MAX_PKT) + 1;
  localparam int TW = ep_clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LW-1:0] MAX_PKT_LW = LW'(MAX_PKT);
  localparam logic [PW-1:0] MAX_PKT_PW = PW'(MAX_PKT);
  localparam logic [TW-1:0] TIMEOUT_TW = TW'(FLUSH_TIMEOUT);

  ep_state_e       r_state;
  ep_state_e       w_next;
  logic [PW-1:0]   r_pkt_len;
  logic [PW-1:0]   r_byte_cnt;
  logic [TW-1:0]   r_timer;
  logic [LW-1:0]   w_level;
  logic [PW-1:0]   w_take;
  logic [7:0]      w_head;
  logic            w_rst;
  logic            w_wr;
  logic            w_full;
  logic            w_empty;
  logic            w_grant_ok;
  logic            w_put;
  logic            w_last;
  logic            w_timeout;
  logic            w_zlp;

  assign w_rst      = reset || usb_reset;
  assign w_wr       = ep_if.uart_in_valid && !w_full;
  assign w_grant_ok = ep_if.in_ep_grant && ep_if.in_ep_data_free;
  assign w_timeout  = (r_timer == TIMEOUT_TW);
  assign w_put      = (r_state == ST_FILL) && w_grant_ok && (r_byte_cnt < r_pkt_len);
  assign w_last     = w_put && (r_byte_cnt + PW'(1) == r_pkt_len);
  assign w_take     = (w_level >= MAX_PKT_LW) ? MAX_PKT_PW : w_level[PW-1:0];
  assign o_fifo_level = w_level;

  usb_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_rst     (w_rst),
    .i_wr_en   (ep_if.uart_in_valid),
    .i_wr_data (ep_if.uart_in_data),
    .i_rd_en   (w_put),
    .o_rd_data (w_head),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

`ifdef USB_IN_EP_ZLP_EN
  logic r_zlp_pending;

  // Armed when a full-size packet drains the FIFO; any new byte cancels it.
  always_ff @(posedge clk) begin
    if (w_rst || w_wr) begin
      r_zlp_pending <= 1'b0;
    end else if (w_last && (r_pkt_len == MAX_PKT_PW) && (w_level == LW'(1))) begin
      r_zlp_pending <= 1'b1;
    end else if ((r_state == ST_REQ) && w_grant_ok) begin
      r_zlp_pending <= 1'b0;
    end
  end
  assign w_zlp = r_zlp_pending;
`else
  assign w_zlp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_rst || w_wr || (w_next != ST_IDLE)) begin
      r_timer <= '0;
    end else if ((!w_empty || w_zlp) && !w_timeout) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_pkt_len  <= '0;
      r_byte_cnt <= '0;
    end else if ((r_state == ST_REQ) && w_grant_ok) begin
      r_pkt_len  <= w_take;
      r_byte_cnt <= '0;
    end else if (w_put) begin
      r_byte_cnt <= r_byte_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if ((w_level >= MAX_PKT_LW) || (w_timeout && (!w_empty || w_zlp))) w_next = ST_REQ;
      end
      // An empty FIFO here can only mean a zero-length packet.
      ST_REQ: begin
        if (w_grant_ok) w_next = w_empty ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ep_if.in_ep_acked) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ep_if.in_ep_req       = 1'b0;
    ep_if.in_ep_data_put  = w_put;
    ep_if.in_ep_data      = 8'h00;
    ep_if.in_ep_data_done = 1'b0;
    ep_if.in_ep_stall     = 1'b0;
    ep_if.uart_in_ready   = !w_full;
    case (r_state)
      ST_REQ:  ep_if.in_ep_req = 1'b1;
      ST_FILL: begin
        ep_if.in_ep_req  = 1'b1;
        ep_if.in_ep_data = w_head;
      end
      ST_DONE: begin
        ep_if.in_ep_req       = 1'b1;
        ep_if.in_ep_data_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_usb_uart_in_pkt_ep.sv
// tb/tb_usb_uart_in_pkt_ep.sv - directed self-checking bench for usb_uart_in_pkt_ep
module tb_usb_uart_in_pkt_ep;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_reset;
  logic [6:0] level;

  logic [7:0] rx_q[$];
  int         pkt_q[$];
  int         cur_len = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  usb_uart_in_pkt_ep_if bus();

  usb_uart_in_pkt_ep #(
    .FIFO_DEPTH    (64),
    .MAX_PKT       (32),
    .FLUSH_TIMEOUT (TO)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .usb_reset    (usb_reset),
    .ep_if        (bus),
    .o_fifo_level (level)
  );

  // PE-side observer: collects payload bytes and per-packet lengths
  always @(negedge clk) begin
    if (reset || usb_reset) begin
      cur_len = 0;
    end else begin
      if (bus.in_ep_data_put) begin
        rx_q.push_back(bus.in_ep_data);
        cur_len++;
      end
      if (bus.in_ep_data_done) begin
        pkt_q.push_back(cur_len);
        cur_len = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    usb_reset           = 1'b0;
    bus.uart_in_valid   = 1'b0;
    bus.uart_in_data    = 8'h00;
    bus.in_ep_grant     = 1'b1;
    bus.in_ep_data_free = 1'b1;
    bus.in_ep_acked     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rx_q.delete();
    pkt_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bus.uart_in_data  = b;
    bus.uart_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.uart_in_ready;
      @(posedge clk);
      #1;
    end
    bus.uart_in_valid = 1'b0;
  endtask

  task automatic send_seq(input string tag, input int first, input int count);
    bit ok;
    int nok = 0;
    for (int i = 0; i < count; i++) begin
      send_byte(8'(first + i), ok);
      if (!ok) nok++;
    end
    chk(tag, nok, 0);
  endtask

  task automatic wait_pkts(input string tag, input int n);
    for (int i = 0; i < 2000 && pkt_q.size() < n; i++) @(posedge clk);
    #1;
    chk(tag, pkt_q.size(), n);
  endtask

  task automatic check_bytes(input string tag, input int start, input int first, input int count);
    int bad = 0;
    for (int i = 0; i < count; i++) begin
      if (start + i >= rx_q.size()) bad++;
      else if (rx_q[start + i] !== 8'(first + i)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    bit ok;
    int paused;

    do_reset();
    @(negedge clk);
    chk("rst_req", bus.in_ep_req, 0);
    chk("rst_put", bus.in_ep_data_put, 0);
    chk("rst_done", bus.in_ep_data_done, 0);
    chk("rst_stall", bus.in_ep_stall, 0);
    chk("rst_ready", bus.uart_in_ready, 1);
    chk("rst_data", bus.in_ep_data, 0);
    chk("rst_level", level, 0);

    // short packet after idle timeout
    do_reset();
    send_seq("t1_wr", 8'h41, 5);
    repeat (TO / 2) @(posedge clk);
    chk("t1_early", pkt_q.size(), 0);
    wait_pkts("t1_npkt", 1);
    chk("t1_len", pkt_q[0], 5);
    check_bytes("t1_data", 0, 8'h41, 5);
    @(negedge clk);
    chk("t1_level", level, 0);

    // 70-byte burst splits into 32/32/6
    do_reset();
    send_seq("t2_wr", 0, 70);
    wait_pkts("t2_npkt", 3);
    chk("t2_len0", pkt_q[0], 32);
    chk("t2_len1", pkt_q[1], 32);
    chk("t2_len2", pkt_q[2], 6);
    check_bytes("t2_data", 0, 0, 70);
    @(negedge clk);
    chk("t2_level", level, 0);

    // full FIFO back-pressures the source without dropping the held byte
    do_reset();
    bus.in_ep_grant = 1'b0;
    bus.in_ep_acked = 1'b0;
    send_seq("t3_wr", 8'h80, 64);
    @(negedge clk);
    chk("t3_level_full", level, 64);
    chk("t3_ready_full", bus.uart_in_ready, 0);
    bus.uart_in_data  = 8'hEE;
    bus.uart_in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_hold_level", level, 64);
    bus.in_ep_grant = 1'b1;
    bus.in_ep_acked = 1'b1;
    send_byte(8'hEE, ok);
    chk("t3_held_taken", ok, 1);
    wait_pkts("t3_npkt", 3);
    chk("t3_len2", pkt_q[2], 1);
    check_bytes("t3_data", 0, 8'h80, 64);
    chk("t3_last", (rx_q.size() > 64) ? rx_q[64] : 8'h00, 8'hEE);

    // data_free dropped mid-packet
    do_reset();
    send_seq("t4_wr", 8'h10, 32);
    for (int i = 0; i < 200 && cur_len < 5; i++) @(posedge clk);
    #1 bus.in_ep_data_free = 1'b0;
    paused = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ep_data_put) paused++;
    end
    chk("t4_pause_put", paused, 0);
    bus.in_ep_data_free = 1'b1;
    wait_pkts("t4_npkt", 1);
    chk("t4_len", pkt_q[0], 32);
    check_bytes("t4_data", 0, 8'h10, 32);
    repeat (20) @(posedge clk);
    chk("t4_one_done", pkt_q.size(), 1);

    // bus reset abandons the packet in flight
    do_reset();
    send_seq("t5_wr", 8'h20, 32);
    for (int i = 0; i < 200 && cur_len < 10; i++) @(posedge clk);
    #1 usb_reset = 1'b1;
    @(posedge clk);
    #1 usb_reset = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 0);
    chk("t5_ready", bus.uart_in_ready, 1);
    chk("t5_req", bus.in_ep_req, 0);
    repeat (TO + 50) @(posedge clk);
    chk("t5_no_done", pkt_q.size(), 0);

    // exact MAX_PKT payload
    do_reset();
    send_seq("t6_wr", 8'h60, 32);
`ifdef USB_IN_EP_ZLP_EN
    wait_pkts("t6_npkt", 2);
    chk("t6_len0", pkt_q[0], 32);
    chk("t6_zlp_len", (pkt_q.size() > 1) ? pkt_q[1] : -1, 0);
`else
    wait_pkts("t6_npkt", 1);
    chk("t6_len0", pkt_q[0], 32);
    repeat (TO * 3) @(posedge clk);
    chk("t6_no_zlp", pkt_q.size(), 1);
`endif
    chk("t6_bytes", rx_q.size(), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
